systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Input-side transmitter for the 4x4 systolic array. It accepts activation vectors (one element per array row) over a valid/ready stream and buffers them in a small FIFO. It drives the array's `in_left[4]` with the diagonal skew the array expects: row k is delayed k cycles relative to row 0. It also drives `in_up[4]` with zero partial sums, and brackets each tile with a drain phase so consecutive tiles never overlap inside the skew chain.

## Interface
- `WIDTH`, 16, signed data width per element; matches the array's `WIDTH`.
- `DEPTH`, 4, FIFO depth in vectors; power of two, at least 2.

- `clk`, input, 1, rising-edge clock.
- `rst`, input, 1, reset, synchronous, active-high.
- `s_valid`, input, 1, upstream vector valid.
- `s_ready`, output, 1, feeder can accept a vector.
- `s_data[4]`, input, 4 x `WIDTH` signed, activation vector; element k goes to array row k.
- `s_last`, input, 1, marks the final vector of a tile.
- `in_left[4]`, output, 4 x `WIDTH` signed, skewed activations to the array's left edge.
- `in_up[4]`, output, 4 x `WIDTH` signed, top-edge partial-sum injection; always 0.
- `busy`, output, 1, FIFO non-empty, or any valid element in the skew chain, or state is not IDLE.
- `tile_done`, output, 1, one-cycle pulse when the last element of a tile leaves on `in_left[3]`.

## Operation
- **Accept:** a beat is taken on an edge where `s_valid && s_ready`. `{s_data, s_last}` is written to the FIFO.
- **Ready:** `s_ready = !full && !rst`, derived from the registered occupancy count. There is no bypass, so a full FIFO never accepts a beat, even on an edge with a pop.
- **Read latency:** a written entry becomes poppable on the following edge. There is no fall-through.
- **Issue stage:** on each edge, the feeder pops one vector if the FIFO is non-empty and the state is not DRAIN.
  - Popped vector: element k enters skew lane k.
  - No pop: a zero bubble (data 0, valid 0, last 0) enters every lane.
- **Skew lanes:** lane k is a chain of k+1 registers. `in_left[k]` is the tail of lane k. A valid bit and a last bit travel with the data.
- **Array independence:** the array is free-running; the feeder never stalls it. Bubbles are real zeros.
- **`in_up`:** all four outputs are registered constant 0.
- **States:**
  - IDLE:
    - pop of a non-last vector -> RUN;
    - pop of a last vector -> DRAIN;
    - no pop -> stay.
  - RUN:
    - pop of a last vector -> DRAIN;
    - otherwise stay. Empty-FIFO cycles insert bubbles and stay in RUN.
  - DRAIN: no pops; writes are still accepted. A 2-bit counter counts 3 edges, then the state goes -> IDLE.
- **`tile_done`:** equals the last bit at the tail of lane 3.
- **Arithmetic:** pure data movement, no arithmetic. Signed values pass through bit-exact.

## Timing
- **Reset values:** `in_left` = 0, `in_up` = 0, `s_ready` = 0 while `rst` is high, `busy` = 0, `tile_done` = 0. State is IDLE, FIFO is empty, and all lane valid/last bits are 0.
- **Mid-tile reset:** discards the FIFO and lanes. No `tile_done` is produced for the aborted tile.
- **Latency for a beat accepted at edge E0 into an empty FIFO:**
  - pop at E1;
  - `in_left[k]` holds element k during the cycle after edge E(1+k);
  - `in_left[0]` is first visible after E1, `in_left[3]` after E4.
- **Last vector popped at edge Ep:**
  - state is DRAIN after Ep;
  - `tile_done` is high for exactly the cycle after Ep+3;
  - state is IDLE after Ep+3;
  - the next tile's earliest pop is at Ep+4, so its element 0 appears one cycle after the previous tile's element 3.
- **Single-vector tile (`s_last` on the first beat):** IDLE -> DRAIN directly, with the same Ep+3 `tile_done` timing.
- **Throughput:** 1 vector per cycle within a tile. Tile gap is 3 bubble cycles on the issue stage.
- **Full:** occupancy equals `DEPTH` -> `s_ready` = 0 in the same cycle. With a pop and no push at that edge, `s_ready` = 1 on the next cycle.
- **Empty with a push:** occupancy becomes 1; the pop happens on the next edge.
- **`busy`:** falls in the cycle after `tile_done` if the FIFO is empty.

## Test plan
- **Single tile:** vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16}, `s_last` on the 4th, `s_valid` held high.
  - Required: `in_left[0]` shows 1,5,9,13 starting 1 cycle after the first accept edge;
  - `in_left[3]` shows 4,8,12,16 starting 3 cycles later;
  - `tile_done` is high in the same cycle as 16 on `in_left[3]`;
  - zeros appear outside those windows.
- **Backpressure:** push 6 non-last vectors back-to-back from reset, with `DEPTH`=4.
  - Required: `s_ready` drops only when occupancy reaches 4; no beat is lost or duplicated;
  - `in_left[0]` emits the 6 values in order with no bubbles once streaming.
- **One-vector tile:** {-1,-32768,32767,0} with `s_last`.
  - Required: values appear bit-exact on lanes 0..3 at successive cycles, sign preserved;
  - `tile_done` fires exactly 3 cycles after `in_left[0]` = -1.
- **Back-to-back tiles:** two 2-vector tiles pushed continuously.
  - Required: exactly 3 issue-stage bubble cycles between the tiles;
  - the second tile's element 0 is first seen the cycle after the first tile's `tile_done`;
  - two `tile_done` pulses in total.
- **Reset mid-tile:** assert `rst` for 1 cycle after 2 of 4 vectors are accepted.
  - Required: all outputs are 0 the next cycle, `busy` = 0, no `tile_done`;
  - a new 1-vector tile afterwards behaves as in the one-vector-tile scenario.
- **Bubble insertion:** in RUN, stall `s_valid` for 2 cycles mid-tile.
  - Required: 2 zero cycles appear in every lane, skewed by lane index;
  - state stays RUN and `tile_done` timing is measured from the last pop.

Source files
------------

// File: rtl/systolic_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : systolic_feeder
//  Description : Input-side transmitter for a 4x4 systolic array. Buffers
//                activation vectors from a valid/ready stream in a small FIFO,
//                issues one vector per cycle into diagonally skewed lanes
//                (lane k delayed k cycles relative to lane 0), drives zero
//                partial sums on the top edge, and inserts a three-cycle drain
//                gap after each tile.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_feeder #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_data [4],
    input  logic                    s_last,
    output logic signed [WIDTH-1:0] in_left [4],
    output logic signed [WIDTH-1:0] in_up [4],
    output logic                    busy,
    output logic                    tile_done
);

    localparam int c_LANES = 4;
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [1:0]         c_DRAIN_LAST = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_CNT_W-1:0] count_q;
    logic [DEPTH-1:0]   mem_last_q;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] drain_cnt_q;
    logic [1:0] drain_cnt_d;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_issue_last;

    // Ready comes from the registered count only; a full FIFO refuses a beat
    // even on an edge that also pops, because there is no bypass path.
    assign w_full  = (count_q == c_CNT_FULL);
    assign w_empty = (count_q == '0);
    assign s_ready = !w_full && !rst;
    assign w_push  = s_valid && s_ready;
    assign w_pop   = !w_empty && (state_q != S_DRAIN);

    assign w_issue_last = w_pop && mem_last_q[rd_ptr_q];

    // Tile-end markers stored alongside the per-lane data entries
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_last_q[wr_ptr_q] <= s_last;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^n
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_CNT_ONE;
                2'b01:   count_q <= count_q - c_CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Tile sequencing FSM
    // ------------------------------------------------------------------------
    // State and drain counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state: a popped last vector starts a three-edge drain with no pops
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    state_d     = w_issue_last ? S_DRAIN : S_RUN;
                    drain_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (w_issue_last) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == c_DRAIN_LAST) begin
                    state_d     = S_IDLE;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                drain_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Valid / last sidebands. Stage s of every lane holds the same issue slot,
    // so one 4-deep valid pipe tells whether any lane holds a live element.
    // The last marker is only observed where it leaves lane 3, so it travels
    // in a pipe matching lane 3's depth.
    // ------------------------------------------------------------------------
    logic [c_LANES-1:0] vld_pipe_q;
    logic [c_LANES-1:0] last_pipe_q;

    // Shift the issue-slot valid and last markers down the skew depth
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            vld_pipe_q  <= {vld_pipe_q[c_LANES-2:0], w_pop};
            last_pipe_q <= {last_pipe_q[c_LANES-2:0], w_issue_last};
        end
    end

    assign tile_done = last_pipe_q[c_LANES-1];
    assign busy      = !w_empty || (|vld_pipe_q) || (state_q != S_IDLE);

    // ------------------------------------------------------------------------
    // Per-lane storage and skew chains
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < c_LANES; k++) begin : g_lane
        localparam int c_LEN = k + 1;

        logic signed [WIDTH-1:0] mem_q [DEPTH];
        logic signed [WIDTH-1:0] w_tap [c_LEN+1];
        logic signed [WIDTH-1:0] up_q;

        // FIFO column for this lane's element
        always_ff @(posedge clk) begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= s_data[k];
            end
        end

        // A non-popping edge injects a real zero so the array sees clean bubbles
        assign w_tap[0] = w_pop ? mem_q[rd_ptr_q] : '0;

        for (genvar s = 0; s < c_LEN; s++) begin : g_stage
            logic signed [WIDTH-1:0] dat_q;

            // One skew register; lane k chains k+1 of these
            always_ff @(posedge clk) begin
                if (rst) begin
                    dat_q <= '0;
                end else begin
                    dat_q <= w_tap[s];
                end
            end

            assign w_tap[s+1] = dat_q;
        end

        // Top-edge partial sums are always a registered zero
        always_ff @(posedge clk) begin
            up_q <= '0;
        end

        assign in_left[k] = w_tap[c_LEN];
        assign in_up[k]   = up_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_feeder
//  Description : Self-checking bench for systolic_feeder: a cycle table for a
//                full four-vector tile plus directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

    localparam int WIDTH = 16;
    localparam int NCYC  = 32;

    logic clk = 1'b0;
    logic rst;
    logic s_valid;
    logic s_ready;
    logic s_last;
    logic busy;
    logic tile_done;
    logic signed [WIDTH-1:0] s_data  [4];
    logic signed [WIDTH-1:0] in_left [4];
    logic signed [WIDTH-1:0] in_up   [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    systolic_feeder #(.WIDTH(WIDTH), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .in_left   (in_left),
        .in_up     (in_up),
        .busy      (busy),
        .tile_done (tile_done)
    );

    typedef struct packed {
        logic            rst;
        logic            vld;
        logic            last;
        logic [3:0][15:0] d;
        logic [3:0][15:0] e;
        logic            rdy;
        logic            bsy;
        logic            td;
    } vec_t;

    vec_t tbl [12];

    // per-cycle stimulus and captured outputs for the directed sequences
    logic st_rst  [NCYC];
    logic st_vld  [NCYC];
    logic st_last [NCYC];
    int   st_d    [NCYC][4];
    int   tr_l    [NCYC][4];
    logic tr_td   [NCYC];
    logic tr_rdy  [NCYC];
    logic tr_busy [NCYC];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic l,
                                input int d0, input int d1, input int d2, input int d3,
                                input int e0, input int e1, input int e2, input int e3,
                                input logic rdy, input logic bsy, input logic td);
        vec_t t;
        t.rst  = r;   t.vld  = v;   t.last = l;
        t.d[0] = 16'(d0); t.d[1] = 16'(d1); t.d[2] = 16'(d2); t.d[3] = 16'(d3);
        t.e[0] = 16'(e0); t.e[1] = 16'(e1); t.e[2] = 16'(e2); t.e[3] = 16'(e3);
        t.rdy  = rdy; t.bsy  = bsy; t.td   = td;
        return t;
    endfunction

    task automatic clear_stim();
        for (int c = 0; c < NCYC; c++) begin
            st_rst[c] = 1'b0; st_vld[c] = 1'b0; st_last[c] = 1'b0;
            for (int k = 0; k < 4; k++) st_d[c][k] = 0;
        end
    endtask

    task automatic beat(input int c, input logic l, input int a, input int b, input int x, input int y);
        st_vld[c]  = 1'b1;
        st_last[c] = l;
        st_d[c][0] = a; st_d[c][1] = b; st_d[c][2] = x; st_d[c][3] = y;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        for (int k = 0; k < 4; k++) s_data[k] = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Applies the stimulus arrays one cycle at a time and records outputs
    // mid-cycle, with the cycle's inputs already applied.
    task automatic run(input string nm, input int n);
        for (int c = 0; c < n; c++) begin
            rst     = st_rst[c];
            s_valid = st_vld[c];
            s_last  = st_last[c];
            for (int k = 0; k < 4; k++) s_data[k] = 16'(st_d[c][k]);
            #1;
            for (int k = 0; k < 4; k++) begin
                tr_l[c][k] = int'(in_left[k]);
                chk($sformatf("%s in_up%0d c%0d", nm, k, c), int'(in_up[k]), 0);
            end
            tr_td[c]   = tile_done;
            tr_rdy[c]  = s_ready;
            tr_busy[c] = busy;
            @(posedge clk); #1;
        end
        rst = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    endtask

    initial begin
        int pulses;
        int e0 [9];
        int e1 [8];
        int e2 [6];
        int e3 [7];

        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        for (int k = 0; k < 4; k++) s_data[k] = '0;
        @(posedge clk); #1;

        // ---------------- single four-vector tile, cycle table ----------------
        tbl[0]  = mk(1,0,0,  0, 0, 0, 0,   0, 0, 0, 0,  0,0,0);
        tbl[1]  = mk(0,1,0,  1, 2, 3, 4,   0, 0, 0, 0,  1,0,0);
        tbl[2]  = mk(0,1,0,  5, 6, 7, 8,   0, 0, 0, 0,  1,1,0);
        tbl[3]  = mk(0,1,0,  9,10,11,12,   1, 0, 0, 0,  1,1,0);
        tbl[4]  = mk(0,1,1, 13,14,15,16,   5, 2, 0, 0,  1,1,0);
        tbl[5]  = mk(0,0,0,  0, 0, 0, 0,   9, 6, 3, 0,  1,1,0);
        tbl[6]  = mk(0,0,0,  0, 0, 0, 0,  13,10, 7, 4,  1,1,0);
        tbl[7]  = mk(0,0,0,  0, 0, 0, 0,   0,14,11, 8,  1,1,0);
        tbl[8]  = mk(0,0,0,  0, 0, 0, 0,   0, 0,15,12,  1,1,0);
        tbl[9]  = mk(0,0,0,  0, 0, 0, 0,   0, 0, 0,16,  1,1,1);
        tbl[10] = mk(0,0,0,  0, 0, 0, 0,   0, 0, 0, 0,  1,0,0);
        tbl[11] = mk(0,0,0,  0, 0, 0, 0,   0, 0, 0, 0,  1,0,0);

        for (int i = 0; i < 12; i++) begin
            rst     = tbl[i].rst;
            s_valid = tbl[i].vld;
            s_last  = tbl[i].last;
            for (int k = 0; k < 4; k++) s_data[k] = tbl[i].d[k];
            #1;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("tile r%0d in_left%0d", i, k), int'(in_left[k]), int'($signed(tbl[i].e[k])));
                chk($sformatf("tile r%0d in_up%0d", i, k), int'(in_up[k]), 0);
            end
            chk($sformatf("tile r%0d s_ready", i), int'(s_ready), int'(tbl[i].rdy));
            chk($sformatf("tile r%0d busy", i), int'(busy), int'(tbl[i].bsy));
            chk($sformatf("tile r%0d tile_done", i), int'(tile_done), int'(tbl[i].td));
            @(posedge clk); #1;
        end
        rst = 1'b0; s_valid = 1'b0; s_last = 1'b0;

        // ---------------- backpressure: six non-last beats ----------------
        do_reset(); clear_stim();
        for (int j = 1; j <= 6; j++) beat(j - 1, 1'b0, j, j + 10, j + 20, j + 30);
        run("bp", 12);
        for (int c = 0; c < 8; c++) chk($sformatf("bp s_ready c%0d", c), int'(tr_rdy[c]), 1);
        for (int j = 1; j <= 6; j++) begin
            chk($sformatf("bp lane0 beat%0d", j), tr_l[j + 1][0], j);
            chk($sformatf("bp lane3 beat%0d", j), tr_l[j + 4][3], j + 30);
        end
        chk("bp lane0 before", tr_l[1][0], 0);
        chk("bp lane0 after", tr_l[8][0], 0);
        for (int c = 0; c < 12; c++) chk($sformatf("bp tile_done c%0d", c), int'(tr_td[c]), 0);

        // ---------------- one-vector tile, extreme signed values ----------------
        do_reset(); clear_stim();
        beat(0, 1'b1, -1, -32768, 32767, 0);
        run("ov", 10);
        chk("ov lane0", tr_l[2][0], -1);
        chk("ov lane1", tr_l[3][1], -32768);
        chk("ov lane2", tr_l[4][2], 32767);
        chk("ov lane3", tr_l[5][3], 0);
        chk("ov lane0 early", tr_l[1][0], 0);
        chk("ov lane0 once", tr_l[3][0], 0);
        chk("ov lane1 once", tr_l[4][1], 0);
        chk("ov lane2 once", tr_l[5][2], 0);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("ov tile_done c%0d", c), int'(tr_td[c]), int'(c == 5));
            chk($sformatf("ov busy c%0d", c), int'(tr_busy[c]), int'(c >= 1 && c <= 5));
        end

        // ---------------- back-to-back two-vector tiles ----------------
        do_reset(); clear_stim();
        beat(0, 1'b0, 1, 2, 3, 4);
        beat(1, 1'b1, 5, 6, 7, 8);
        beat(2, 1'b0, 9, 10, 11, 12);
        beat(3, 1'b1, 13, 14, 15, 16);
        run("bb", 16);
        e0 = '{0, 1, 5, 0, 0, 0, 9, 13, 0};
        for (int i = 0; i < 9; i++) chk($sformatf("bb lane0 c%0d", i + 1), tr_l[i + 1][0], e0[i]);
        e3 = '{4, 8, 0, 0, 0, 12, 16};
        for (int i = 0; i < 7; i++) chk($sformatf("bb lane3 c%0d", i + 5), tr_l[i + 5][3], e3[i]);
        for (int c = 0; c < 4; c++) chk($sformatf("bb s_ready c%0d", c), int'(tr_rdy[c]), 1);
        pulses = 0;
        for (int c = 0; c < 16; c++) begin
            if (tr_td[c]) pulses++;
            chk($sformatf("bb tile_done c%0d", c), int'(tr_td[c]), int'(c == 6 || c == 11));
        end
        chk("bb pulse count", pulses, 2);
        chk("bb busy end", int'(tr_busy[12]), 0);

        // ---------------- reset mid-tile, then a one-vector tile ----------------
        do_reset(); clear_stim();
        beat(0, 1'b0, 1, 2, 3, 4);
        beat(1, 1'b0, 5, 6, 7, 8);
        st_rst[2] = 1'b1;
        beat(4, 1'b1, -1, -32768, 32767, 0);
        run("rm", 14);
        chk("rm lane0 pre", tr_l[2][0], 1);
        chk("rm s_ready in rst", int'(tr_rdy[2]), 0);
        for (int k = 0; k < 4; k++) chk($sformatf("rm lane%0d post", k), tr_l[3][k], 0);
        chk("rm busy post", int'(tr_busy[3]), 0);
        chk("rm s_ready post", int'(tr_rdy[3]), 1);
        chk("rm busy idle", int'(tr_busy[4]), 0);
        chk("rm new lane0", tr_l[6][0], -1);
        chk("rm new lane1", tr_l[7][1], -32768);
        chk("rm new lane2", tr_l[8][2], 32767);
        chk("rm new lane3", tr_l[9][3], 0);
        for (int c = 0; c < 14; c++) chk($sformatf("rm tile_done c%0d", c), int'(tr_td[c]), int'(c == 9));
        chk("rm busy end", int'(tr_busy[10]), 0);

        // ---------------- bubble insertion in RUN ----------------
        do_reset(); clear_stim();
        beat(0, 1'b0, 1, 11, 21, 31);
        beat(1, 1'b0, 2, 12, 22, 32);
        beat(4, 1'b0, 3, 13, 23, 33);
        beat(5, 1'b1, 4, 14, 24, 34);
        run("bub", 14);
        e1 = '{0, 1, 2, 0, 0, 3, 4, 0};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("bub lane0 c%0d", i + 1), tr_l[i + 1][0], e1[i]);
            chk($sformatf("bub lane1 c%0d", i + 2), tr_l[i + 2][1], (e1[i] == 0) ? 0 : e1[i] + 10);
        end
        e2 = '{21, 22, 0, 0, 23, 24};
        for (int i = 0; i < 6; i++) chk($sformatf("bub lane2 c%0d", i + 4), tr_l[i + 4][2], e2[i]);
        e3 = '{31, 32, 0, 0, 33, 34, 0};
        for (int i = 0; i < 7; i++) chk($sformatf("bub lane3 c%0d", i + 5), tr_l[i + 5][3], e3[i]);
        for (int c = 0; c < 14; c++) begin
            chk($sformatf("bub tile_done c%0d", c), int'(tr_td[c]), int'(c == 10));
            chk($sformatf("bub busy c%0d", c), int'(tr_busy[c]), int'(c >= 1 && c <= 10));
        end

        // ---------------- FIFO fills during drain ----------------
        do_reset(); clear_stim();
        beat(0, 1'b1, 7, 7, 7, 7);
        for (int j = 1; j <= 4; j++) beat(j, 1'b0, 40 + j, 50 + j, 60 + j, 70 + j);
        beat(5, 1'b0, 45, 55, 65, 75);
        beat(6, 1'b0, 45, 55, 65, 75);
        run("fl", 14);
        for (int c = 0; c < 7; c++) chk($sformatf("fl s_ready c%0d", c), int'(tr_rdy[c]), int'(c != 5));
        e0 = '{7, 0, 0, 0, 41, 42, 43, 44, 45};
        for (int i = 0; i < 9; i++) chk($sformatf("fl lane0 c%0d", i + 2), tr_l[i + 2][0], e0[i]);
        chk("fl lane0 no dup", tr_l[11][0], 0);
        for (int c = 0; c < 14; c++) chk($sformatf("fl tile_done c%0d", c), int'(tr_td[c]), int'(c == 5));
        chk("fl busy full", int'(tr_busy[5]), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
